// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared opcodes, FSM encoding and widths for regfile_ctrl
package regfile_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int IDX_W  = 2;

    typedef enum logic [1:0] {
        OP_LOADI = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_AND   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_EXEC  = 2'b10,
        ST_WRITE = 2'b11
    } state_e;

endpackage

// File: rtl/regfile_alu.sv
// rtl/regfile_alu.sv - combinational datapath for LOADI/ADD/SUB/AND
module regfile_alu
    import regfile_ctrl_pkg::*;
(
    input  op_e               op,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] value,
    output logic              carry,
    output logic              carry_valid
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    always_comb begin
        sum         = {1'b0, op1} + {1'b0, op2};
        // bit 8 of the 9-bit difference is set exactly when op1 < op2
        diff        = {1'b0, op1} - {1'b0, op2};
        value       = imm;
        carry       = 1'b0;
        carry_valid = 1'b0;
        case (op)
            OP_LOADI: value = imm;
            OP_ADD: begin
                value       = sum[DATA_W-1:0];
                carry       = sum[DATA_W];
                carry_valid = 1'b1;
            end
            OP_SUB: begin
                value       = diff[DATA_W-1:0];
                carry       = diff[DATA_W];
                carry_valid = 1'b1;
            end
            OP_AND: value = op1 & op2;
            default: value = imm;
        endcase
    end

endmodule

// File: rtl/regfile_ctrl.sv
// rtl/regfile_ctrl.sv - four-state initiator driving the 4x8 register file ports
module regfile_ctrl
    import regfile_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [1:0]        instr_op,
    input  logic [IDX_W-1:0]  instr_dst,
    input  logic [IDX_W-1:0]  instr_src1,
    input  logic [IDX_W-1:0]  instr_src2,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [IDX_W-1:0]  rf_read_index1,
    output logic [IDX_W-1:0]  rf_read_index2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic              rf_write,
    output logic [IDX_W-1:0]  rf_write_index,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    state_e            state_q,  state_d;
    op_e               op_q,     op_d;
    logic [IDX_W-1:0]  dst_q,    dst_d;
    logic [IDX_W-1:0]  src1_q,   src1_d;
    logic [IDX_W-1:0]  src2_q,   src2_d;
    logic [DATA_W-1:0] imm_q,    imm_d;
    logic [DATA_W-1:0] op1_q,    op1_d;
    logic [DATA_W-1:0] op2_q,    op2_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              carry_q,  carry_d;

    logic [DATA_W-1:0] alu_value;
    logic              alu_carry;
    logic              alu_carry_valid;

    regfile_alu u_alu (
        .op          (op_q),
        .op1         (op1_q),
        .op2         (op2_q),
        .imm         (imm_q),
        .value       (alu_value),
        .carry       (alu_carry),
        .carry_valid (alu_carry_valid)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dst_d    = dst_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        imm_d    = imm_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        result_d = result_q;
        carry_d  = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    op_d    = op_e'(instr_op);
                    dst_d   = instr_dst;
                    src1_d  = instr_src1;
                    src2_d  = instr_src2;
                    imm_d   = instr_imm;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                // operands captured here, before this instruction's own write
                op1_d   = rf_read_data1;
                op2_d   = rf_read_data2;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                result_d = alu_value;
                if (alu_carry_valid) begin
                    carry_d = alu_carry;
                end
                state_d = ST_WRITE;
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_LOADI;
            dst_q    <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            imm_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            imm_q    <= imm_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign instr_ready    = (state_q == ST_IDLE);
    assign rf_read_index1 = src1_q;
    assign rf_read_index2 = src2_q;
    assign rf_write       = (state_q == ST_WRITE) & ~clear;
    assign done           = (state_q == ST_WRITE) & ~clear;
    assign rf_write_index = dst_q;
    assign rf_write_data  = result_q;
    assign result         = result_q;
    assign carry          = carry_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb/tb_regfile_ctrl.sv - self-checking bench for regfile_ctrl with a 4x8 register file model
module tb_regfile_ctrl;

    logic       clock = 1'b0;
    logic       clear;
    logic       instr_valid;
    logic       instr_ready;
    logic [1:0] instr_op;
    logic [1:0] instr_dst;
    logic [1:0] instr_src1;
    logic [1:0] instr_src2;
    logic [7:0] instr_imm;
    logic [1:0] rf_read_index1;
    logic [1:0] rf_read_index2;
    logic [7:0] rf_read_data1;
    logic [7:0] rf_read_data2;
    logic       rf_write;
    logic [1:0] rf_write_index;
    logic [7:0] rf_write_data;
    logic       done;
    logic [7:0] result;
    logic       carry;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] rf_mem [4];
    int         ref_reg [4];
    int         ref_carry;

    regfile_ctrl dut (
        .clock          (clock),
        .clear          (clear),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_op       (instr_op),
        .instr_dst      (instr_dst),
        .instr_src1     (instr_src1),
        .instr_src2     (instr_src2),
        .instr_imm      (instr_imm),
        .rf_read_index1 (rf_read_index1),
        .rf_read_index2 (rf_read_index2),
        .rf_read_data1  (rf_read_data1),
        .rf_read_data2  (rf_read_data2),
        .rf_write       (rf_write),
        .rf_write_index (rf_write_index),
        .rf_write_data  (rf_write_data),
        .done           (done),
        .result         (result),
        .carry          (carry)
    );

    always #5 clock = ~clock;

    // register file: combinational reads, write captured on the falling edge
    assign rf_read_data1 = rf_mem[rf_read_index1];
    assign rf_read_data2 = rf_mem[rf_read_index2];
    always @(negedge clock) begin
        if (clear) begin
            for (int i = 0; i < 4; i++) rf_mem[i] <= 8'h00;
        end else if (rf_write) begin
            rf_mem[rf_write_index] <= rf_write_data;
        end
    end

    typedef struct {
        logic [1:0] op;
        logic [1:0] dst;
        logic [1:0] s1;
        logic [1:0] s2;
        logic [7:0] imm;
        logic [7:0] exp_res;
        logic       exp_c;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, int'(instr_ready), 1);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_rf_write"}, int'(rf_write), 0);
        chk({tag, "_result"}, int'(result), 0);
        chk({tag, "_carry"}, int'(carry), 0);
        chk({tag, "_rd_idx"}, int'({rf_read_index1, rf_read_index2}), 0);
        chk({tag, "_wr_idx"}, int'(rf_write_index), 0);
        chk({tag, "_wr_data"}, int'(rf_write_data), 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        instr_valid = 1'b0;
        step();
        step();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) ref_reg[i] = 0;
        ref_carry = 0;
    endtask

    task automatic run_instr(input string name, input logic [1:0] op, input logic [1:0] dst,
                             input logic [1:0] s1, input logic [1:0] s2, input logic [7:0] imm,
                             input int exp_res, input int exp_c);
        int wait_cnt;
        int lat;
        wait_cnt = 0;
        while (!instr_ready && wait_cnt < 10) begin
            step();
            wait_cnt++;
        end
        if (!instr_ready) chk({name, "_ready_timeout"}, 0, 1);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_dst   = dst;
        instr_src1  = s1;
        instr_src2  = s2;
        instr_imm   = imm;
        step();
        instr_valid = 1'b0;
        instr_imm   = $urandom_range(255, 0);
        chk({name, "_busy"}, int'(instr_ready), 0);
        lat = 1;
        while (!done && lat < 8) begin
            step();
            lat++;
        end
        chk({name, "_latency"}, lat, 3);
        chk({name, "_result"}, int'(result), exp_res);
        chk({name, "_carry"}, int'(carry), exp_c);
        chk({name, "_wr"}, int'({rf_write, rf_write_index}), int'({1'b1, dst}));
        chk({name, "_wr_data"}, int'(rf_write_data), exp_res);
        step();
        chk({name, "_ready_back"}, int'(instr_ready), 1);
        chk({name, "_done_pulse"}, int'(done), 0);
        chk({name, "_rf"}, int'(rf_mem[dst]), exp_res);
    endtask

    initial begin
        int accepts;
        int dones;
        logic rdy_hist [8];
        int a, b, r, c, s;
        logic [1:0] op, dst, s1, s2;
        logic [7:0] imm;

        clear       = 1'b0;
        instr_valid = 1'b0;
        instr_op    = 2'b00;
        instr_dst   = 2'b00;
        instr_src1  = 2'b00;
        instr_src2  = 2'b00;
        instr_imm   = 8'h00;
        step();
        do_clear();
        check_reset_outputs("reset");

        vecs[0] = '{2'b00, 2'd0, 2'd0, 2'd0, 8'h5A, 8'h5A, 1'b0};
        vecs[1] = '{2'b00, 2'd1, 2'd0, 2'd0, 8'hA7, 8'hA7, 1'b0};
        vecs[2] = '{2'b01, 2'd2, 2'd0, 2'd1, 8'h00, 8'h01, 1'b1};
        vecs[3] = '{2'b01, 2'd3, 2'd2, 2'd2, 8'h00, 8'h02, 1'b0};
        vecs[4] = '{2'b10, 2'd3, 2'd2, 2'd1, 8'h00, 8'h5A, 1'b1};
        vecs[5] = '{2'b10, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0};
        vecs[6] = '{2'b00, 2'd0, 2'd0, 2'd0, 8'h5A, 8'h5A, 1'b0};
        vecs[7] = '{2'b10, 2'd2, 2'd2, 2'd1, 8'h00, 8'h5A, 1'b1};
        vecs[8] = '{2'b11, 2'd1, 2'd1, 2'd0, 8'h00, 8'h02, 1'b1};
        vecs[9] = '{2'b01, 2'd1, 2'd1, 2'd1, 8'h00, 8'h04, 1'b0};

        for (int i = 0; i < 10; i++) begin
            run_instr($sformatf("vec%0d", i), vecs[i].op, vecs[i].dst, vecs[i].s1, vecs[i].s2,
                      vecs[i].imm, int'(vecs[i].exp_res), int'(vecs[i].exp_c));
        end
        chk("final_r0", int'(rf_mem[0]), 8'h5A);
        chk("final_r2", int'(rf_mem[2]), 8'h5A);
        chk("final_r3", int'(rf_mem[3]), 8'h5A);

        // valid held high: accepts only when ready, one per four cycles
        instr_valid = 1'b1;
        instr_op    = 2'b00;
        instr_dst   = 2'd3;
        instr_src1  = 2'd0;
        instr_src2  = 2'd0;
        instr_imm   = 8'h11;
        accepts = 0;
        dones   = 0;
        for (int i = 0; i < 8; i++) begin
            rdy_hist[i] = instr_ready;
            if (instr_ready) accepts++;
            step();
            if (done) dones++;
        end
        instr_valid = 1'b0;
        chk("hold_accepts", accepts, 2);
        chk("hold_dones", dones, 2);
        chk("hold_ready_pattern", int'({rdy_hist[0], rdy_hist[1], rdy_hist[2], rdy_hist[3], rdy_hist[4]}), 5'b10001);
        step();
        chk("hold_r3", int'(rf_mem[3]), 8'h11);
        chk("hold_carry_kept", int'(carry), 0);

        // clear asserted during EXEC of ADD r2=r0+r1
        instr_valid = 1'b1;
        instr_op    = 2'b01;
        instr_dst   = 2'd2;
        instr_src1  = 2'd0;
        instr_src2  = 2'd1;
        step();
        instr_valid = 1'b0;
        step();
        clear = 1'b1;
        dones = 0;
        step();
        if (done || rf_write) dones++;
        clear = 1'b0;
        check_reset_outputs("midclear");
        for (int i = 0; i < 5; i++) begin
            step();
            if (done || rf_write) dones++;
        end
        chk("midclear_no_retire", dones, 0);
        chk("midclear_r2", int'(rf_mem[2]), 0);

        // clear and valid together: nothing latched
        clear       = 1'b1;
        instr_valid = 1'b1;
        instr_op    = 2'b00;
        instr_dst   = 2'd0;
        instr_imm   = 8'hFF;
        step();
        step();
        chk("clrvalid_ready", int'(instr_ready), 1);
        clear       = 1'b0;
        instr_valid = 1'b0;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done) dones++;
        end
        chk("clrvalid_no_done", dones, 0);
        chk("clrvalid_r0", int'(rf_mem[0]), 0);

        // randomized instructions against an arithmetic reference model
        do_clear();
        for (int n = 0; n < 40; n++) begin
            op  = 2'($urandom_range(3, 0));
            dst = 2'($urandom_range(3, 0));
            s1  = 2'($urandom_range(3, 0));
            s2  = 2'($urandom_range(3, 0));
            imm = 8'($urandom_range(255, 0));
            a = ref_reg[s1];
            b = ref_reg[s2];
            c = ref_carry;
            case (op)
                2'b00: r = int'(imm);
                2'b01: begin
                    s = a + b;
                    r = s % 256;
                    c = (s > 255) ? 1 : 0;
                end
                2'b10: begin
                    r = (a - b + 256) % 256;
                    c = (a < b) ? 1 : 0;
                end
                default: r = a & b;
            endcase
            ref_reg[dst] = r;
            ref_carry    = c;
            run_instr($sformatf("rnd%0d", n), op, dst, s1, s2, imm, r, c);
        end
        for (int i = 0; i < 4; i++) chk($sformatf("rnd_final_r%0d", i), int'(rf_mem[i]), ref_reg[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
